// File: rtl/gpio_port_ctrl.sv
// rtl/gpio_port_ctrl.sv - parametrised GPIO port with edge/level IRQs; optional debounce via GPIO_DEBOUNCE_EN
module gpio_port_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DEB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel_i,
    input  logic             we_i,
    input  logic [4:0]       addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic             ack_o,
    input  logic [WIDTH-1:0] gpio_in_i,
    output logic [WIDTH-1:0] gpio_out_o,
    output logic [WIDTH-1:0] gpio_oe_o,
    output logic             irq_o
);

    localparam logic [2:0] REG_DIR    = 3'd0;
    localparam logic [2:0] REG_OUT    = 3'd1;
    localparam logic [2:0] REG_IN     = 3'd2;
    localparam logic [2:0] REG_EN     = 3'd3;
    localparam logic [2:0] REG_MODE   = 3'd4;
    localparam logic [2:0] REG_POL    = 3'd5;
    localparam logic [2:0] REG_STATUS = 3'd6;
    localparam logic [2:0] REG_TGL    = 3'd7;

    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] en_q, en_d;
    logic [WIDTH-1:0] mode_q, mode_d;
    logic [WIDTH-1:0] pol_q, pol_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ack_q, ack_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] in_val;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] wbits;
    logic [WIDTH-1:0] rise, fall, edge_evt, level_evt, evt;
    logic [2:0]       reg_idx;

    // Only bits [4:2] decode a register and only the low WIDTH data bits land anywhere.
    logic unused_bits;
    assign unused_bits = ^{addr_i[1:0], wdata_i};

    assign reg_idx = addr_i[4:2];
    assign wbits   = wdata_i[WIDTH-1:0];

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]         deb_q, deb_d;

    // Per-pin stability counter: IN follows sync2 only after DEB_CYCLES consecutive differing cycles.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] >= CW'(DEB_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            deb_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign in_val = deb_q;
`else
    assign in_val = sync2_q;
`endif

    // Bus decode: register writes, W1C mask and registered read data.
    always_comb begin
        dir_d   = dir_q;
        out_d   = out_q;
        en_d    = en_q;
        mode_d  = mode_q;
        pol_d   = pol_q;
        w1c     = '0;
        rdata_d = '0;
        ack_d   = sel_i;
        if (sel_i && we_i) begin
            case (reg_idx)
                REG_DIR:    dir_d  = wbits;
                REG_OUT:    out_d  = wbits;
                REG_EN:     en_d   = wbits;
                REG_MODE:   mode_d = wbits;
                REG_POL:    pol_d  = wbits;
                REG_STATUS: w1c    = wbits;
                REG_TGL:    out_d  = out_q ^ wbits;
                default:    ;
            endcase
        end
        if (sel_i && !we_i) begin
            case (reg_idx)
                REG_DIR:    rdata_d = 32'(dir_q);
                REG_OUT:    rdata_d = 32'(out_q);
                REG_IN:     rdata_d = 32'(in_val);
                REG_EN:     rdata_d = 32'(en_q);
                REG_MODE:   rdata_d = 32'(mode_q);
                REG_POL:    rdata_d = 32'(pol_q);
                REG_STATUS: rdata_d = 32'(status_q);
                default:    rdata_d = '0;
            endcase
        end
    end

    // Input synchroniser, event detection and sticky status where a new event beats a W1C.
    always_comb begin
        sync1_d   = gpio_in_i;
        sync2_d   = sync1_q;
        prev_d    = in_val;
        rise      = in_val & ~prev_q;
        fall      = ~in_val & prev_q;
        edge_evt  = (rise & ~pol_q) | (fall & pol_q);
        level_evt = in_val ^ pol_q;
        evt       = (mode_q & level_evt) | (~mode_q & edge_evt);
        status_d  = (status_q & ~w1c) | evt;
        irq_d     = |(status_q & en_q);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q    <= '1;
            out_q    <= '0;
            en_q     <= '0;
            mode_q   <= '0;
            pol_q    <= '0;
            status_q <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            dir_q    <= dir_d;
            out_q    <= out_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            pol_q    <= pol_d;
            status_q <= status_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            irq_q    <= irq_d;
        end
    end

    assign gpio_out_o = out_q;
    assign gpio_oe_o  = ~dir_q;
    assign rdata_o    = rdata_q;
    assign ack_o      = ack_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// tb/tb_gpio_port_ctrl.sv - directed self-checking bench for gpio_port_ctrl
module tb_gpio_port_ctrl;

    localparam int WIDTH = 8;
`ifdef GPIO_DEBOUNCE_EN
    localparam int EXTRA = 16;
`else
    localparam int EXTRA = 0;
`endif

    localparam logic [4:0] A_DIR    = 5'h00;
    localparam logic [4:0] A_OUT    = 5'h04;
    localparam logic [4:0] A_IN     = 5'h08;
    localparam logic [4:0] A_EN     = 5'h0C;
    localparam logic [4:0] A_MODE   = 5'h10;
    localparam logic [4:0] A_POL    = 5'h14;
    localparam logic [4:0] A_STATUS = 5'h18;
    localparam logic [4:0] A_TGL    = 5'h1C;

    logic             clk = 1'b0;
    logic             rst;
    logic             sel;
    logic             we;
    logic [4:0]       addr;
    logic [31:0]      wdata;
    logic [31:0]      rdata_o;
    logic             ack_o;
    logic [WIDTH-1:0] gpio_in;
    logic [WIDTH-1:0] gpio_out;
    logic [WIDTH-1:0] gpio_oe;
    logic             irq_o;
    logic [WIDTH-1:0] pad_ext;

    int checks = 0;
    int errors = 0;

    gpio_port_ctrl #(.WIDTH(WIDTH), .DEB_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .sel_i      (sel),
        .we_i       (we),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .rdata_o    (rdata_o),
        .ack_o      (ack_o),
        .gpio_in_i  (gpio_in),
        .gpio_out_o (gpio_out),
        .gpio_oe_o  (gpio_oe),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    // Pad model: driven pins loop back, the rest follow the external stimulus.
    assign gpio_in = (gpio_oe & gpio_out) | (~gpio_oe & pad_ext);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0;
        check("wr_ack", 32'(ack_o), 32'd1);
    endtask

    task automatic expect_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        @(negedge clk);
        sel = 1'b1; we = 1'b0; addr = a; wdata = '0;
        @(posedge clk);
        #1;
        sel = 1'b0;
        check("rd_ack", 32'(ack_o), 32'd1);
        check(tag, rdata_o, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rst_vals [8];
        rst_vals = '{32'hFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

        rst = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; pad_ext = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset values and register readback.
        check("rst_oe", 32'(gpio_oe), 32'h0);
        check("rst_out", 32'(gpio_out), 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        check("rst_ack", 32'(ack_o), 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        for (int i = 0; i < 8; i++)
            expect_reg($sformatf("rst_rd_%0d", i), 5'(i * 4), rst_vals[i]);
        @(posedge clk);
        #1;
        check("ack_single", 32'(ack_o), 32'h0);
        check("rdata_idle", rdata_o, 32'h0);

        // Direction, output and toggle with loopback.
        bus_write(A_DIR, 32'hF0);
        check("oe_0f", 32'(gpio_oe), 32'h0F);
        bus_write(A_OUT, 32'hA5);
        check("out_a5", 32'(gpio_out), 32'hA5);
        bus_write(A_TGL, 32'h0F);
        check("out_aa", 32'(gpio_out), 32'hAA);
        repeat (3 + EXTRA) @(posedge clk);
        expect_reg("in_loop", A_IN, 32'h0A);
        bus_write(A_IN, 32'hFF);
        expect_reg("in_ro", A_IN, 32'h0A);
        expect_reg("tgl_rd0", A_TGL, 32'h0);
        expect_reg("out_rd", A_OUT, 32'hAA);
        bus_write(A_DIR, 32'hFF);
        repeat (4 + EXTRA) @(posedge clk);
        bus_write(A_STATUS, 32'hFF);
        expect_reg("stat_clr", A_STATUS, 32'h0);
        check("irq_noen", 32'(irq_o), 32'h0);

        // Rising edge on bit 0: status at k+2, irq at k+3.
        bus_write(A_EN, 32'h01);
        @(negedge clk);
        pad_ext[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("irq_k1", 32'(irq_o), 32'h0);
        repeat (EXTRA) @(posedge clk);
        @(posedge clk);
        #1;
        check("irq_k2", 32'(irq_o), 32'h0);
        @(posedge clk);
        #1;
        check("irq_k3", 32'(irq_o), 32'h1);
        expect_reg("stat_rise", A_STATUS, 32'h01);
        bus_write(A_STATUS, 32'h01);
        check("irq_w1c_hold", 32'(irq_o), 32'h1);
        @(posedge clk);
        #1;
        check("irq_w1c_drop", 32'(irq_o), 32'h0);
        @(negedge clk);
        pad_ext[0] = 1'b0;
        repeat (5 + EXTRA) @(posedge clk);
        expect_reg("stat_fall", A_STATUS, 32'h0);
        check("irq_fall", 32'(irq_o), 32'h0);

        // Level-low on bit 3: W1C while asserted is re-set.
        bus_write(A_MODE, 32'h08);
        bus_write(A_POL, 32'h08);
        bus_write(A_EN, 32'h08);
        repeat (3) @(posedge clk);
        expect_reg("lvl_set", A_STATUS, 32'h08);
        check("lvl_irq", 32'(irq_o), 32'h1);
        bus_write(A_STATUS, 32'h08);
        expect_reg("lvl_w1c_held", A_STATUS, 32'h08);
        check("lvl_irq_held", 32'(irq_o), 32'h1);
        @(negedge clk);
        pad_ext[3] = 1'b1;
        repeat (4 + EXTRA) @(posedge clk);
        bus_write(A_STATUS, 32'h08);
        @(posedge clk);
        #1;
        check("lvl_irq_drop", 32'(irq_o), 32'h0);
        expect_reg("lvl_clr", A_STATUS, 32'h0);

        // Edge event on bit 2 coinciding with W1C of bit 2: set wins.
        @(negedge clk);
        pad_ext[2] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        repeat (EXTRA) @(posedge clk);
        bus_write(A_STATUS, 32'h04);
        expect_reg("set_wins", A_STATUS, 32'h04);
        bus_write(A_STATUS, 32'h04);
        expect_reg("set_then_clr", A_STATUS, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
        // Debounce: short glitch filtered, stable level accepted.
        @(negedge clk);
        pad_ext[1] = 1'b1;
        repeat (10) @(negedge clk);
        pad_ext[1] = 1'b0;
        repeat (30) @(posedge clk);
        expect_reg("deb_glitch_in", A_IN, 32'h0C);
        expect_reg("deb_glitch_st", A_STATUS, 32'h0);
        @(negedge clk);
        pad_ext[1] = 1'b1;
        repeat (25) @(posedge clk);
        expect_reg("deb_stable_in", A_IN, 32'h0E);
        expect_reg("deb_stable_st", A_STATUS, 32'h02);
`endif

        // Reset in the middle of a request with an interrupt pending.
        bus_write(A_EN, 32'h04);
        @(negedge clk);
        pad_ext[2] = 1'b0;
        repeat (4 + EXTRA) @(posedge clk);
        @(negedge clk);
        pad_ext[2] = 1'b1;
        repeat (4 + EXTRA) @(posedge clk);
        #1;
        check("pre_rst_irq", 32'(irq_o), 32'h1);
        @(negedge clk);
        rst = 1'b1; sel = 1'b1; we = 1'b0; addr = A_IN; pad_ext = '0;
        @(posedge clk);
        #1;
        sel = 1'b0;
        check("mid_rst_ack", 32'(ack_o), 32'h0);
        check("mid_rst_irq", 32'(irq_o), 32'h0);
        check("mid_rst_rdata", rdata_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        expect_reg("post_rst_stat", A_STATUS, 32'h0);
        expect_reg("post_rst_dir", A_DIR, 32'hFF);
        check("post_rst_oe", 32'(gpio_oe), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
